// File: rtl/kitchen_defs.sv
// Shared kitchen definitions: scheduler state encodings and default parameters.
package kitchen_defs;

  typedef enum logic [1:0] {
    MS_IDLE  = 2'd0,
    MS_WAKE  = 2'd1,
    MS_COOK  = 2'd2,
    MS_SERVE = 2'd3
  } ms_state_t;

  localparam int MS_DEF_N_KIDS       = 4;
  localparam int MS_DEF_COOK_CYCLES  = 4;
  localparam int MS_DEF_WAKE_TIMEOUT = 15;

endpackage

// File: rtl/meal_sched_if.sv
// Request/grant bundle between the kids and the meal scheduler.
// meal_count exists only when MEAL_SCHED_COUNT_EN is defined.
interface meal_sched_if
  import kitchen_defs::*;
#(
  parameter int N_KIDS = MS_DEF_N_KIDS
);
  logic [N_KIDS-1:0] hungry;
  logic              food;
  logic              wakeup;
  logic [N_KIDS-1:0] grant;
  logic [N_KIDS-1:0] served;
  logic              timeout;
`ifdef MEAL_SCHED_COUNT_EN
  logic [7:0]        meal_count;

  modport master (output hungry, food, input wakeup, grant, served, timeout, meal_count);
  modport slave  (input hungry, food, output wakeup, grant, served, timeout, meal_count);
`else
  modport master (output hungry, food, input wakeup, grant, served, timeout);
  modport slave  (input hungry, food, output wakeup, grant, served, timeout);
`endif
endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit searching upward from ptr, wrapping at N-1.
// Purely combinational; pick is one-hot or all-zero.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick
);

  logic [PW:0] idx;
  logic        found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!found && req[idx[PW-1:0]]) begin
        pick[idx[PW-1:0]] = 1'b1;
        found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/meal_sched.sv
// Round-robin meal scheduler: IDLE -> WAKE -> COOK -> SERVE, all outputs registered.
// Min request-to-served latency COOK_CYCLES+3; no preemption. MEAL_SCHED_COUNT_EN adds meal_count.
module meal_sched
  import kitchen_defs::*;
#(
  parameter int N_KIDS       = MS_DEF_N_KIDS,
  parameter int COOK_CYCLES  = MS_DEF_COOK_CYCLES,
  parameter int WAKE_TIMEOUT = MS_DEF_WAKE_TIMEOUT
) (
  input  logic         clk,
  input  logic         resetb,
  meal_sched_if.slave  bus
);

  localparam int PW = $clog2(N_KIDS);

  ms_state_t         state, state_nxt;
  logic [N_KIDS-1:0] grant_q, grant_nxt, served_q, served_nxt, pick;
  logic              wakeup_q, wakeup_nxt, timeout_q, timeout_nxt;
  logic [PW-1:0]     rr_ptr, rr_ptr_nxt, win_idx, ptr_after;
  logic [3:0]        cook_cnt, cook_cnt_nxt, wait_cnt, wait_cnt_nxt;
  logic              hungry_lost;

  rr_pick #(.N(N_KIDS), .PW(PW)) u_pick (
    .req  (bus.hungry),
    .ptr  (rr_ptr),
    .pick (pick)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_KIDS; i++) begin
      if (grant_q[i]) win_idx = PW'(i);
    end
    ptr_after = (win_idx == PW'(N_KIDS - 1)) ? '0 : win_idx + PW'(1);
  end

  assign hungry_lost = ~|(bus.hungry & grant_q);

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_q;
    served_nxt   = '0;
    wakeup_nxt   = wakeup_q;
    timeout_nxt  = 1'b0;
    rr_ptr_nxt   = rr_ptr;
    cook_cnt_nxt = cook_cnt;
    wait_cnt_nxt = wait_cnt;
    case (state)
      MS_IDLE: begin
        grant_nxt  = '0;
        wakeup_nxt = 1'b0;
        if (|bus.hungry) begin
          grant_nxt    = pick;
          wakeup_nxt   = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = MS_WAKE;
        end
      end
      MS_WAKE: begin
        // Abort outranks both food and timeout.
        if (hungry_lost) begin
          grant_nxt  = '0;
          wakeup_nxt = 1'b0;
          rr_ptr_nxt = ptr_after;
          state_nxt  = MS_IDLE;
        end else if (bus.food) begin
          cook_cnt_nxt = 4'(COOK_CYCLES - 1);
          state_nxt    = MS_COOK;
        end else if (wait_cnt == 4'(WAKE_TIMEOUT - 1)) begin
          timeout_nxt = 1'b1;
          grant_nxt   = '0;
          wakeup_nxt  = 1'b0;
          rr_ptr_nxt  = ptr_after;
          state_nxt   = MS_IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end
      MS_COOK: begin
        if (hungry_lost) begin
          grant_nxt  = '0;
          wakeup_nxt = 1'b0;
          rr_ptr_nxt = ptr_after;
          state_nxt  = MS_IDLE;
        end else if (cook_cnt == 4'd0) begin
          served_nxt = grant_q;
          wakeup_nxt = 1'b0;
          state_nxt  = MS_SERVE;
        end else begin
          cook_cnt_nxt = cook_cnt - 4'd1;
        end
      end
      MS_SERVE: begin
        grant_nxt  = '0;
        wakeup_nxt = 1'b0;
        rr_ptr_nxt = ptr_after;
        state_nxt  = MS_IDLE;
      end
      default: state_nxt = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= MS_IDLE;
      grant_q   <= '0;
      served_q  <= '0;
      wakeup_q  <= 1'b0;
      timeout_q <= 1'b0;
      rr_ptr    <= '0;
      cook_cnt  <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      grant_q   <= grant_nxt;
      served_q  <= served_nxt;
      wakeup_q  <= wakeup_nxt;
      timeout_q <= timeout_nxt;
      rr_ptr    <= rr_ptr_nxt;
      cook_cnt  <= cook_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.served  = served_q;
  assign bus.wakeup  = wakeup_q;
  assign bus.timeout = timeout_q;

`ifdef MEAL_SCHED_COUNT_EN
  logic [7:0] meal_cnt;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) meal_cnt <= '0;
    else if (state == MS_COOK && state_nxt == MS_SERVE) meal_cnt <= meal_cnt + 8'd1;
  end

  assign bus.meal_count = meal_cnt;
`endif

endmodule

// File: tb/tb_meal_sched.sv
// Scoreboarded bench for meal_sched: served pulses are checked against an expected queue.
module tb_meal_sched;

  localparam int NK = 4;
  localparam int CC = 4;
  localparam int WT = 15;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [NK-1:0] exp_q[$];
  logic [NK-1:0] exp_v;

  meal_sched_if #(.N_KIDS(NK)) bus ();

  meal_sched #(.N_KIDS(NK), .COOK_CYCLES(CC), .WAKE_TIMEOUT(WT)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Monitor: grant one-hot every cycle, served pulses popped from the scoreboard.
  always @(negedge clk) begin
    if (resetb) begin
      checks++;
      if ($countones(bus.grant) > 1) begin
        errors++;
        $display("FAIL grant_onehot: grant=%b, required at most one bit", bus.grant);
      end
      if (bus.served != '0) begin
        checks++;
        if ((bus.served & ~bus.grant) != '0) begin
          errors++;
          $display("FAIL served_subset: served=%b grant=%b", bus.served, bus.grant);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL served_unexpected: served=%b, required no pulse", bus.served);
        end else begin
          exp_v = exp_q.pop_front();
          if (bus.served !== exp_v) begin
            errors++;
            $display("FAIL served_order: served=%b, required %b", bus.served, exp_v);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    resetb     = 1'b0;
    bus.hungry = '0;
    bus.food   = 1'b0;
    exp_q.delete();
    tick;
    tick;
    resetb = 1'b1;
  endtask

  task automatic test_reset;
    resetb     = 1'b0;
    bus.hungry = '1;
    bus.food   = 1'b1;
    tick;
    checks++;
    if (bus.wakeup !== 1'b0) begin errors++; $display("FAIL reset_wakeup: got %b, required 0", bus.wakeup); end
    checks++;
    if (bus.grant !== '0) begin errors++; $display("FAIL reset_grant: got %b, required 0000", bus.grant); end
    checks++;
    if (bus.served !== '0) begin errors++; $display("FAIL reset_served: got %b, required 0000", bus.served); end
    checks++;
    if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b, required 0", bus.timeout); end
`ifdef MEAL_SCHED_COUNT_EN
    checks++;
    if (bus.meal_count !== 8'd0) begin errors++; $display("FAIL reset_meal_count: got %0d, required 0", bus.meal_count); end
`endif
    bus.hungry = 4'b0100;
    bus.food   = 1'b0;
    resetb     = 1'b1;
    tick;
    checks++;
    if (bus.grant !== 4'b0100) begin errors++; $display("FAIL first_grant: got %b, required 0100", bus.grant); end
    checks++;
    if (bus.wakeup !== 1'b1) begin errors++; $display("FAIL first_wakeup: got %b, required 1", bus.wakeup); end
    bus.hungry = '0;
    tick;
    checks++;
    if (bus.grant !== '0) begin errors++; $display("FAIL early_abort_grant: got %b, required 0000", bus.grant); end
  endtask

  task automatic test_single;
    int cyc;
    int wk;
    logic got;
    do_reset;
    bus.food   = 1'b1;
    bus.hungry = 4'b0001;
    exp_q.push_back(4'b0001);
    tick;
    cyc = 1;
    got = 1'b0;
    wk  = bus.wakeup ? 1 : 0;
    checks++;
    if (bus.grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b, required 0001", bus.grant); end
    while (!got && cyc < 20) begin
      tick;
      cyc++;
      if (bus.wakeup) wk++;
      if (bus.served != '0) begin
        got = 1'b1;
        bus.hungry = '0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      if (bus.wakeup) wk++;
    end
    checks++;
    if (!got || (cyc + 1) != CC + 3) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles (seen=%b), required %0d", cyc + 1, got, CC + 3);
    end
    checks++;
    if (wk != CC + 1) begin errors++; $display("FAIL single_wakeup_len: got %0d, required %0d", wk, CC + 1); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL single_pending: %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_fairness;
    int cyc;
    int n;
    do_reset;
    bus.food   = 1'b1;
    bus.hungry = 4'b1111;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    cyc = 0;
    n   = 0;
    while (n < 5 && cyc < 100) begin
      tick;
      cyc++;
      if (bus.served != '0) begin
        n++;
        if (n == 5) bus.hungry = '0;
      end
    end
    tick;
    tick;
    checks++;
    if (n != 5) begin errors++; $display("FAIL fair_count: got %0d meals, required 5", n); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL fair_pending: %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_timeout;
    int cyc;
    logic seen;
    do_reset;
    bus.food   = 1'b0;
    bus.hungry = 4'b0100;
    tick;
    checks++;
    if (bus.grant !== 4'b0100) begin errors++; $display("FAIL to_grant: got %b, required 0100", bus.grant); end
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      tick;
      cyc++;
      if (bus.timeout) seen = 1'b1;
    end
    checks++;
    if (!seen || cyc != WT) begin errors++; $display("FAIL to_cycles: got %0d (seen=%b), required %0d", cyc, seen, WT); end
    checks++;
    if (bus.grant !== '0 || bus.wakeup !== 1'b0) begin
      errors++;
      $display("FAIL to_release: grant=%b wakeup=%b, required 0000/0", bus.grant, bus.wakeup);
    end
    bus.hungry = 4'b1100;
    tick;
    checks++;
    if (bus.grant !== 4'b1000) begin errors++; $display("FAIL to_next_grant: got %b, required 1000", bus.grant); end
    checks++;
    if (bus.timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_len: got %b, required 0", bus.timeout); end
    bus.hungry = '0;
    tick;
    tick;
  endtask

  task automatic test_abort;
    int cyc;
    logic got;
    do_reset;
    bus.food   = 1'b1;
    bus.hungry = 4'b0010;
    tick;
    tick;
    tick;
    checks++;
    if (bus.wakeup !== 1'b1 || bus.grant !== 4'b0010) begin
      errors++;
      $display("FAIL abort_cooking: wakeup=%b grant=%b, required 1/0010", bus.wakeup, bus.grant);
    end
    bus.hungry = '0;
    tick;
    checks++;
    if (bus.grant !== '0 || bus.wakeup !== 1'b0 || bus.served !== '0) begin
      errors++;
      $display("FAIL abort_idle: grant=%b wakeup=%b served=%b, required 0000/0/0000", bus.grant, bus.wakeup, bus.served);
    end
    bus.hungry = 4'b0110;
    exp_q.push_back(4'b0100);
    tick;
    checks++;
    if (bus.grant !== 4'b0100) begin errors++; $display("FAIL abort_rr_ptr: grant=%b, required 0100", bus.grant); end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      tick;
      cyc++;
      if (bus.served != '0) begin
        got = 1'b1;
        bus.hungry = '0;
      end
    end
    tick;
    tick;
    checks++;
    if (!got || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_followup: seen=%b pending=%0d, required 1/0", got, exp_q.size());
    end
  endtask

  task automatic test_abort_vs_timeout;
    do_reset;
    bus.food   = 1'b0;
    bus.hungry = 4'b0100;
    for (int t = 0; t < WT; t++) tick;
    bus.hungry = '0;
    tick;
    checks++;
    if (bus.timeout !== 1'b0 || bus.grant !== '0 || bus.wakeup !== 1'b0) begin
      errors++;
      $display("FAIL abort_prio: timeout=%b grant=%b wakeup=%b, required 0/0000/0", bus.timeout, bus.grant, bus.wakeup);
    end
    tick;
    checks++;
    if (bus.timeout !== 1'b0) begin errors++; $display("FAIL abort_prio_late: timeout=%b, required 0", bus.timeout); end
  endtask

  task automatic test_reset_cook;
    int cyc;
    logic got;
    do_reset;
    bus.food   = 1'b1;
    bus.hungry = 4'b0010;
    exp_q.push_back(4'b0010);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      tick;
      cyc++;
      if (bus.served != '0) begin
        got = 1'b1;
        bus.hungry = '0;
      end
    end
    tick;
    tick;
    bus.hungry = 4'b0110;
    tick;
    checks++;
    if (bus.grant !== 4'b0100) begin errors++; $display("FAIL rc_pre_grant: got %b, required 0100", bus.grant); end
    tick;
    tick;
    #2;
    resetb = 1'b0;
    #1;
    checks++;
    if (bus.wakeup !== 1'b0 || bus.grant !== '0) begin
      errors++;
      $display("FAIL rc_async: wakeup=%b grant=%b, required 0/0000", bus.wakeup, bus.grant);
    end
    tick;
    resetb = 1'b1;
    tick;
    checks++;
    if (bus.grant !== 4'b0010) begin errors++; $display("FAIL rc_ptr_cleared: grant=%b, required 0010", bus.grant); end
    bus.hungry = '0;
    tick;
    tick;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rc_pending: %0d left, required 0", exp_q.size()); end
  endtask

`ifdef MEAL_SCHED_COUNT_EN
  task automatic test_meal_count;
    int cyc;
    int n;
    do_reset;
    bus.food   = 1'b1;
    bus.hungry = 4'b0001;
    for (int i = 0; i < 257; i++) exp_q.push_back(4'b0001);
    cyc = 0;
    n   = 0;
    while (n < 257 && cyc < 4000) begin
      tick;
      cyc++;
      if (bus.served != '0) begin
        n++;
        if (n == 257) bus.hungry = '0;
      end
    end
    checks++;
    if (n != 257) begin errors++; $display("FAIL mc_meals: got %0d, required 257", n); end
    checks++;
    if (bus.meal_count !== 8'd1) begin errors++; $display("FAIL mc_wrap: got %0d, required 1", bus.meal_count); end
    tick;
    tick;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mc_pending: %0d left, required 0", exp_q.size()); end
  endtask
`endif

  initial begin
    bus.hungry = '0;
    bus.food   = 1'b0;
    test_reset;
    test_single;
    test_fairness;
    test_timeout;
    test_abort;
    test_abort_vs_timeout;
    test_reset_cook;
`ifdef MEAL_SCHED_COUNT_EN
    test_meal_count;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
